// File: rtl/flit_vc_buffer.sv
// Multi-VC flit buffer: NUM_VC circular queues of DEPTH flits behind one write port,
// drained through a round-robin first-word-fall-through read port.
module flit_vc_buffer #(
  parameter int FLIT_WIDTH = 128,
  parameter int DEPTH      = 4,
  parameter int NUM_VC     = 2,
  parameter int DROP_CNT_W = 16,
  localparam int VC_W      = (NUM_VC > 1) ? $clog2(NUM_VC) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  input  logic [VC_W-1:0]       in_vc,
  input  logic [FLIT_WIDTH-1:0] in_flit,
  output logic                  in_ready,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [VC_W-1:0]       out_vc,
  output logic [FLIT_WIDTH-1:0] out_flit,
  output logic [2*NUM_VC-1:0]   vc_state,
  output logic                  overflow,
  output logic [DROP_CNT_W-1:0] drop_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
  localparam logic [VC_W:0]    NUM_VC_C = (VC_W + 1)'(NUM_VC);

  typedef enum logic [1:0] {
    ST_EMPTY    = 2'd0,
    ST_VACANT   = 2'd1,
    ST_FULL     = 2'd2,
    ST_OVERFULL = 2'd3
  } state_t;

  // Flit storage is deliberately left out of reset.
  logic [FLIT_WIDTH-1:0] data_buffer [NUM_VC][DEPTH];

  logic [PTR_W-1:0] push_index [NUM_VC];
  logic [PTR_W-1:0] pop_index  [NUM_VC];
  logic [CNT_W-1:0] count      [NUM_VC];

  logic [VC_W-1:0]       rr_ptr_reg, rr_ptr_next;
  logic                  overflow_reg;
  logic [DROP_CNT_W-1:0] drop_count_reg;

  logic            in_range, push_ok, drop, handshake, sel_found;
  logic [VC_W-1:0] sel_vc;
  logic [PTR_W-1:0] push_slot;
  logic [VC_W:0]   sel_inc;

  assign in_range = {1'b0, in_vc} < NUM_VC_C;

  // Out-of-range VCs never match the loop, so they read as not ready.
  always_comb begin
    in_ready  = 1'b0;
    push_slot = '0;
    for (int v = 0; v < NUM_VC; v++) begin
      if (in_vc == VC_W'(v)) begin
        in_ready  = (count[v] != DEPTH_C);
        push_slot = push_index[v];
      end
    end
  end

  assign push_ok = in_valid & in_ready & in_range & ~flush;
  assign drop    = in_valid & ~(in_ready & in_range) & ~flush;

  always_comb begin
    logic [VC_W:0] idx;
    idx       = '0;
    sel_found = 1'b0;
    sel_vc    = '0;
    for (int k = 0; k < NUM_VC; k++) begin
      idx = {1'b0, rr_ptr_reg} + (VC_W + 1)'(k);
      if (idx >= NUM_VC_C) idx = idx - NUM_VC_C;
      if (!sel_found && count[idx[VC_W-1:0]] != '0) begin
        sel_found = 1'b1;
        sel_vc    = idx[VC_W-1:0];
      end
    end
  end

  assign out_valid = sel_found;
  assign out_vc    = sel_vc;
  assign out_flit  = data_buffer[sel_vc][pop_index[sel_vc]];
  assign handshake = sel_found & out_ready & ~flush;

  assign sel_inc = {1'b0, sel_vc} + (VC_W + 1)'(1);

  always_comb begin
    rr_ptr_next = rr_ptr_reg;
    if (flush) begin
      rr_ptr_next = '0;
    end else if (handshake) begin
      rr_ptr_next = (sel_inc >= NUM_VC_C) ? '0 : sel_inc[VC_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) data_buffer[in_vc][push_slot] <= in_flit;
  end

  for (genvar gi = 0; gi < NUM_VC; gi++) begin : g_vc
    logic [PTR_W-1:0] push_index_reg, pop_index_reg;
    logic [CNT_W-1:0] count_reg;
    logic             overfull_reg;
    logic             push_here, pop_here, drop_here;
    state_t           state;

    assign push_here = push_ok && (in_vc == VC_W'(gi));
    assign pop_here  = handshake && (sel_vc == VC_W'(gi));
    assign drop_here = drop && in_range && (in_vc == VC_W'(gi));

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        push_index_reg <= '0;
        pop_index_reg  <= '0;
        count_reg      <= '0;
        overfull_reg   <= 1'b0;
      end else if (flush) begin
        push_index_reg <= '0;
        pop_index_reg  <= '0;
        count_reg      <= '0;
        overfull_reg   <= 1'b0;
      end else begin
        if (push_here) push_index_reg <= push_index_reg + PTR_W'(1);
        if (pop_here)  pop_index_reg  <= pop_index_reg + PTR_W'(1);
        if (push_here && !pop_here)      count_reg <= count_reg + CNT_W'(1);
        else if (pop_here && !push_here) count_reg <= count_reg - CNT_W'(1);
        // A pop always ends the overfull episode, even if a drop lands the same cycle.
        if (pop_here)       overfull_reg <= 1'b0;
        else if (drop_here) overfull_reg <= 1'b1;
      end
    end

    always_comb begin
      state = ST_VACANT;
      if (count_reg == '0)           state = ST_EMPTY;
      else if (count_reg == DEPTH_C) state = overfull_reg ? ST_OVERFULL : ST_FULL;
    end

    assign push_index[gi]       = push_index_reg;
    assign pop_index[gi]        = pop_index_reg;
    assign count[gi]            = count_reg;
    assign vc_state[2*gi +: 2]  = state;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_reg     <= '0;
      overflow_reg   <= 1'b0;
      drop_count_reg <= '0;
    end else begin
      rr_ptr_reg   <= rr_ptr_next;
      overflow_reg <= drop;
      if (drop && drop_count_reg != '1) drop_count_reg <= drop_count_reg + DROP_CNT_W'(1);
    end
  end

  assign overflow   = overflow_reg;
  assign drop_count = drop_count_reg;

endmodule

// File: tb/tb_flit_vc_buffer.sv
// Directed bench for flit_vc_buffer (3 VCs so an out-of-range VC is encodable,
// DEPTH 4, 2-bit drop counter to reach saturation quickly).
module tb_flit_vc_buffer;

  localparam int FW = 16;
  localparam int NV = 3;

  logic          clk = 1'b0;
  logic          rst, flush, in_valid, in_ready, out_valid, out_ready, overflow;
  logic [1:0]    in_vc, out_vc, drop_count;
  logic [FW-1:0] in_flit, out_flit;
  logic [5:0]    vc_state;

  int checks = 0;
  int errors = 0;

  flit_vc_buffer #(.FLIT_WIDTH(FW), .DEPTH(4), .NUM_VC(NV), .DROP_CNT_W(2)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_vc(in_vc), .in_flit(in_flit), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready), .out_vc(out_vc), .out_flit(out_flit),
    .vc_state(vc_state), .overflow(overflow), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          iv;
    logic [1:0]    ivc;
    logic [FW-1:0] fl;
    logic          ordy;
    logic          fls;
    logic          e_ird;
    logic          e_ov;
    logic [1:0]    e_ovc;
    logic [FW-1:0] e_of;
    logic [5:0]    e_st;
    logic          e_ofl;
    logic [1:0]    e_dc;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic iv, logic [1:0] ivc, logic [FW-1:0] fl, logic ordy,
                              logic fls, logic e_ird, logic e_ov, logic [1:0] e_ovc,
                              logic [FW-1:0] e_of, logic [5:0] e_st, logic e_ofl,
                              logic [1:0] e_dc);
    vec_t v;
    v.iv = iv; v.ivc = ivc; v.fl = fl; v.ordy = ordy; v.fls = fls;
    v.e_ird = e_ird; v.e_ov = e_ov; v.e_ovc = e_ovc; v.e_of = e_of;
    v.e_st = e_st; v.e_ofl = e_ofl; v.e_dc = e_dc;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Inputs are applied just after a rising edge; outputs are checked on the falling edge.
  task automatic run_vec(int i);
    vec_t v;
    v = vecs[i];
    in_valid = v.iv; in_vc = v.ivc; in_flit = v.fl; out_ready = v.ordy; flush = v.fls;
    @(negedge clk);
    $display("vec %0d: iv=%0d vc=%0d flit=%h ordy=%0d flush=%0d | in_ready=%0d out_valid=%0d out_vc=%0d out_flit=%h vc_state=%b overflow=%0d drop_count=%0d",
             i, v.iv, v.ivc, v.fl, v.ordy, v.fls, in_ready, out_valid, out_vc, out_flit,
             vc_state, overflow, drop_count);
    chk($sformatf("vec%0d in_ready", i), 32'(in_ready), 32'(v.e_ird));
    chk($sformatf("vec%0d out_valid", i), 32'(out_valid), 32'(v.e_ov));
    if (v.e_ov) begin
      chk($sformatf("vec%0d out_vc", i), 32'(out_vc), 32'(v.e_ovc));
      chk($sformatf("vec%0d out_flit", i), 32'(out_flit), 32'(v.e_of));
    end
    chk($sformatf("vec%0d vc_state", i), 32'(vc_state), 32'(v.e_st));
    chk($sformatf("vec%0d overflow", i), 32'(overflow), 32'(v.e_ofl));
    chk($sformatf("vec%0d drop_count", i), 32'(drop_count), 32'(v.e_dc));
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n1;
    logic [FW-1:0] exp_flit;

    // Phase 1: fill VC0, overflow it, pop once, drain.
    vecs.push_back(mk(1, 0, 16'h00A0, 0, 0, 1, 0, 0, 16'h0000, 6'b000000, 0, 0));
    vecs.push_back(mk(1, 0, 16'h00A1, 0, 0, 1, 1, 0, 16'h00A0, 6'b000001, 0, 0));
    vecs.push_back(mk(1, 0, 16'h00A2, 0, 0, 1, 1, 0, 16'h00A0, 6'b000001, 0, 0));
    vecs.push_back(mk(1, 0, 16'h00A3, 0, 0, 1, 1, 0, 16'h00A0, 6'b000001, 0, 0));
    vecs.push_back(mk(1, 0, 16'h00A4, 0, 0, 0, 1, 0, 16'h00A0, 6'b000010, 0, 0));
    vecs.push_back(mk(0, 1, 16'h0000, 0, 0, 1, 1, 0, 16'h00A0, 6'b000011, 1, 1));
    vecs.push_back(mk(0, 0, 16'h0000, 1, 0, 0, 1, 0, 16'h00A0, 6'b000011, 0, 1));
    vecs.push_back(mk(0, 0, 16'h0000, 0, 0, 1, 1, 0, 16'h00A1, 6'b000001, 0, 1));
    vecs.push_back(mk(0, 0, 16'h0000, 1, 0, 1, 1, 0, 16'h00A1, 6'b000001, 0, 1));
    vecs.push_back(mk(0, 0, 16'h0000, 1, 0, 1, 1, 0, 16'h00A2, 6'b000001, 0, 1));
    vecs.push_back(mk(0, 0, 16'h0000, 1, 0, 1, 1, 0, 16'h00A3, 6'b000001, 0, 1));
    vecs.push_back(mk(0, 0, 16'h0000, 0, 0, 1, 0, 0, 16'h0000, 6'b000000, 0, 1));
    n1 = vecs.size();
    // Phase 2: fairness, same-cycle push/pop, out-of-range drops, saturation, flush.
    vecs.push_back(mk(1, 0, 16'h00B0, 0, 0, 1, 0, 0, 16'h0000, 6'b000000, 0, 1));
    vecs.push_back(mk(1, 1, 16'h00C0, 0, 0, 1, 1, 0, 16'h00B0, 6'b000001, 0, 1));
    vecs.push_back(mk(1, 0, 16'h00B1, 0, 0, 1, 1, 0, 16'h00B0, 6'b000101, 0, 1));
    vecs.push_back(mk(1, 1, 16'h00C1, 0, 0, 1, 1, 0, 16'h00B0, 6'b000101, 0, 1));
    vecs.push_back(mk(0, 0, 16'h0000, 1, 0, 1, 1, 0, 16'h00B0, 6'b000101, 0, 1));
    vecs.push_back(mk(0, 0, 16'h0000, 1, 0, 1, 1, 1, 16'h00C0, 6'b000101, 0, 1));
    vecs.push_back(mk(0, 0, 16'h0000, 1, 0, 1, 1, 0, 16'h00B1, 6'b000101, 0, 1));
    vecs.push_back(mk(0, 0, 16'h0000, 1, 0, 1, 1, 1, 16'h00C1, 6'b000100, 0, 1));
    vecs.push_back(mk(1, 0, 16'h00E0, 0, 0, 1, 0, 0, 16'h0000, 6'b000000, 0, 1));
    vecs.push_back(mk(1, 0, 16'h00E1, 0, 0, 1, 1, 0, 16'h00E0, 6'b000001, 0, 1));
    vecs.push_back(mk(1, 0, 16'h00E2, 1, 0, 1, 1, 0, 16'h00E0, 6'b000001, 0, 1));
    vecs.push_back(mk(1, 3, 16'h00FF, 0, 0, 0, 1, 0, 16'h00E1, 6'b000001, 0, 1));
    vecs.push_back(mk(1, 3, 16'h00FF, 0, 0, 0, 1, 0, 16'h00E1, 6'b000001, 1, 2));
    vecs.push_back(mk(1, 3, 16'h00FF, 0, 0, 0, 1, 0, 16'h00E1, 6'b000001, 1, 3));
    vecs.push_back(mk(1, 3, 16'h00FF, 0, 0, 0, 1, 0, 16'h00E1, 6'b000001, 1, 3));
    vecs.push_back(mk(1, 3, 16'h00FF, 0, 0, 0, 1, 0, 16'h00E1, 6'b000001, 1, 3));
    vecs.push_back(mk(1, 1, 16'h0077, 1, 1, 1, 1, 0, 16'h00E1, 6'b000001, 1, 3));
    vecs.push_back(mk(0, 1, 16'h0000, 0, 0, 1, 0, 0, 16'h0000, 6'b000000, 0, 3));
    vecs.push_back(mk(1, 2, 16'h00F0, 0, 0, 1, 0, 0, 16'h0000, 6'b000000, 0, 3));
    vecs.push_back(mk(1, 0, 16'h00F1, 0, 0, 1, 1, 2, 16'h00F0, 6'b010000, 0, 3));
    vecs.push_back(mk(0, 0, 16'h0000, 0, 0, 1, 1, 0, 16'h00F1, 6'b010001, 0, 3));

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_vc = '0; in_flit = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < n1; i++) run_vec(i);

    // Wrap-around on VC1: three rounds of four pushes then four pops.
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < 4; k++) begin
        in_valid = 1'b1; in_vc = 2'd1; in_flit = FW'(16'hD000 + r * 4 + k); out_ready = 1'b0;
        @(negedge clk);
        $display("wrap r%0d push %0d: flit=%h in_ready=%0d", r, k, in_flit, in_ready);
        chk($sformatf("wrap r%0d push%0d in_ready", r, k), 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
      end
      for (int k = 0; k < 4; k++) begin
        in_valid = 1'b0; out_ready = 1'b1;
        exp_flit = FW'(16'hD000 + r * 4 + k);
        @(negedge clk);
        $display("wrap r%0d pop %0d: out_vc=%0d out_flit=%h vc_state=%b", r, k, out_vc, out_flit, vc_state);
        chk($sformatf("wrap r%0d pop%0d out_valid", r, k), 32'(out_valid), 32'd1);
        chk($sformatf("wrap r%0d pop%0d out_vc", r, k), 32'(out_vc), 32'd1);
        chk($sformatf("wrap r%0d pop%0d out_flit", r, k), 32'(out_flit), 32'(exp_flit));
        chk($sformatf("wrap r%0d pop%0d vc_state", r, k), 32'(vc_state),
            (k == 0) ? 32'b001000 : 32'b000100);
        @(posedge clk);
        #1;
      end
    end

    for (int i = n1; i < vecs.size(); i++) run_vec(i);

    // Asynchronous reset while VC0 and VC2 hold data and a push is being presented.
    in_valid = 1'b1; in_vc = 2'd0; in_flit = 16'h0099; out_ready = 1'b0; flush = 1'b0;
    #2 rst = 1'b1;
    #1;
    $display("async reset: out_valid=%0d vc_state=%b overflow=%0d drop_count=%0d in_ready=%0d",
             out_valid, vc_state, overflow, drop_count, in_ready);
    chk("rst out_valid", 32'(out_valid), 32'd0);
    chk("rst vc_state", 32'(vc_state), 32'd0);
    chk("rst overflow", 32'(overflow), 32'd0);
    chk("rst drop_count", 32'(drop_count), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0; in_valid = 1'b0;
    for (int v = 0; v < NV; v++) begin
      in_vc = 2'(v);
      #1;
      $display("post-reset vc%0d: in_ready=%0d", v, in_ready);
      chk($sformatf("post-rst vc%0d in_ready", v), 32'(in_ready), 32'd1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
